line_write_merge_buffer: RTL and testbench

- Parametrised store-coalescing buffer between the CPU write path and a cache/memory line interface; successor to the single-line byte-enable word merger.
- Holds DEPTH line entries; merges byte-masked word writes into matching lines; drains whole lines with a per-byte mask, in FIFO order, over a valid/ready handshake.
- Drain starts when the buffer is full or on an explicit flush.

---
 rtl/line_write_merge_buffer_if.sv | 31 +++
 rtl/line_write_merge_buffer.sv | 247 ++++++++++++++++++++++++
 tb/tb_line_write_merge_buffer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_write_merge_buffer_if.sv
// Write-request and line-drain channels of the store-coalescing buffer.
// The master side drives requests and accepts lines; the slave side is the buffer.
interface line_write_merge_buffer_if #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 2,
  parameter int LINE_BYTES = 16
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_W - OFF_W;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [8*WORD_BYTES-1:0] wr_data;
  logic [WORD_BYTES-1:0]   wr_be;
  logic                    out_valid;
  logic                    out_ready;
  logic [TAG_W-1:0]        out_tag;
  logic [8*LINE_BYTES-1:0] out_line;
  logic [LINE_BYTES-1:0]   out_mask;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, out_ready,
    input  wr_ready, out_valid, out_tag, out_line, out_mask
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be, out_ready,
    output wr_ready, out_valid, out_tag, out_line, out_mask
  );
endinterface

// File: rtl/line_write_merge_buffer.sv
// Store-coalescing buffer: merges byte-masked word writes into DEPTH line entries
// and drains whole lines in FIFO order when full or on flush.
module line_write_merge_buffer #(
  parameter int LINE_BYTES = 16,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  line_write_merge_buffer_if.slave  bus,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      empty,
  output logic                      full
);
  localparam int WB_W   = $clog2(WORD_BYTES);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int WSEL_W = OFF_W - WB_W;
  localparam int WORDS  = LINE_BYTES / WORD_BYTES;
  localparam int DATA_W = 8 * LINE_BYTES;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  logic [DEPTH-1:0]      valid_r;
  logic [TAG_W-1:0]      tag_r  [DEPTH];
  logic [DATA_W-1:0]     data_r [DEPTH];
  logic [LINE_BYTES-1:0] mask_r [DEPTH];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      count_r;
  state_t                state_r;
  logic                  out_valid_r;
  logic [TAG_W-1:0]      out_tag_r;
  logic [DATA_W-1:0]     out_line_r;
  logic [LINE_BYTES-1:0] out_mask_r;
  logic                  flush_active_r;
  logic                  flush_done_r;

  logic [TAG_W-1:0]      wr_tag_s;
  logic [WSEL_W-1:0]     wr_wsel_s;
  logic [LINE_BYTES-1:0] line_be_s;
  logic [DATA_W-1:0]     line_data_s;
  logic [DEPTH-1:0]      hit_vec_s;
  logic                  hit_s;
  logic [PTR_W-1:0]      hit_idx_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_fire_s;
  logic                  merge_s;
  logic                  alloc_s;
  logic                  pop_s;
  logic                  start_s;
  logic                  head_merge_s;
  logic [DATA_W-1:0]     head_line_s;
  logic [LINE_BYTES-1:0] head_mask_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] vec_to_idx(input logic [DEPTH-1:0] v);
    logic [PTR_W-1:0] r;
    r = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      r = r | (v[i] ? PTR_W'(i) : {PTR_W{1'b0}});
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] merge_line(input logic [DATA_W-1:0]     old,
                                                   input logic [DATA_W-1:0]     nw,
                                                   input logic [LINE_BYTES-1:0] be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int k = 0; k < LINE_BYTES; k++) begin
      if (be[k]) begin
        r[8*k +: 8] = nw[8*k +: 8];
      end else begin
        r[8*k +: 8] = old[8*k +: 8];
      end
    end
    return r;
  endfunction

  assign wr_tag_s  = bus.wr_addr[ADDR_W-1:OFF_W];
  assign wr_wsel_s = bus.wr_addr[OFF_W-1:WB_W];

  generate
    if (WB_W > 0) begin : g_unused_lsb
      logic unused_addr_lsb_s;
      assign unused_addr_lsb_s = ^bus.wr_addr[WB_W-1:0];
    end
  endgenerate

  // Spread the incoming word and its byte enables onto line byte positions.
  always_comb begin
    line_be_s   = {LINE_BYTES{1'b0}};
    line_data_s = {DATA_W{1'b0}};
    for (int w = 0; w < WORDS; w++) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        line_be_s[w*WORD_BYTES + i]         = (wr_wsel_s == WSEL_W'(w)) & bus.wr_be[i];
        line_data_s[8*(w*WORD_BYTES+i) +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  // Tag match; the presented head is excluded so its outgoing copy stays frozen.
  always_comb begin
    hit_vec_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec_s[i] = valid_r[i] & (tag_r[i] == wr_tag_s) &
                     ~(out_valid_r & (head_r == PTR_W'(i)));
    end
  end

  assign hit_s     = |hit_vec_s;
  assign hit_idx_s = vec_to_idx(hit_vec_s);
  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});

  assign bus.wr_ready = ~flush_active_r & (hit_s | ~full_s);
  assign wr_fire_s    = bus.wr_valid & bus.wr_ready & (|bus.wr_be);
  assign merge_s      = wr_fire_s & hit_s;
  assign alloc_s      = wr_fire_s & ~hit_s;
  assign pop_s        = out_valid_r & bus.out_ready;
  assign start_s      = (state_r == IDLE) & (full_s | flush_active_r) & ~empty_s;

  // A merge into the head in the cycle it is latched must reach the outgoing copy.
  assign head_merge_s = merge_s & (hit_idx_s == head_r);
  assign head_line_s  = head_merge_s ? merge_line(data_r[head_r], line_data_s, line_be_s)
                                     : data_r[head_r];
  assign head_mask_s  = head_merge_s ? (mask_r[head_r] | line_be_s) : mask_r[head_r];

  // Entry storage: allocate at tail, merge on hit, invalidate head on pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i]  <= {TAG_W{1'b0}};
        data_r[i] <= {DATA_W{1'b0}};
        mask_r[i] <= {LINE_BYTES{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_s && (tail_r == PTR_W'(i))) begin
          valid_r[i] <= 1'b1;
          tag_r[i]   <= wr_tag_s;
          data_r[i]  <= merge_line({DATA_W{1'b0}}, line_data_s, line_be_s);
          mask_r[i]  <= line_be_s;
        end else if (merge_s && (hit_idx_s == PTR_W'(i))) begin
          data_r[i]  <= merge_line(data_r[i], line_data_s, line_be_s);
          mask_r[i]  <= mask_r[i] | line_be_s;
        end else if (pop_s && (head_r == PTR_W'(i))) begin
          valid_r[i] <= 1'b0;
          mask_r[i]  <= {LINE_BYTES{1'b0}};
        end else begin
          valid_r[i] <= valid_r[i];
        end
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (alloc_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end
      case ({alloc_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain FSM; returning to IDLE after each pop forces the one-cycle bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_tag_r   <= {TAG_W{1'b0}};
      out_line_r  <= {DATA_W{1'b0}};
      out_mask_r  <= {LINE_BYTES{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r     <= DRAIN;
            out_valid_r <= 1'b1;
            out_tag_r   <= tag_r[head_r];
            out_line_r  <= head_line_s;
            out_mask_r  <= head_mask_s;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Flush tracking; a flush on an empty buffer with no write landing finishes at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_active_r <= 1'b0;
      flush_done_r   <= 1'b0;
    end else if (flush_active_r) begin
      flush_active_r <= ~empty_s;
      flush_done_r   <= empty_s;
    end else if (flush) begin
      flush_active_r <= ~(empty_s & ~alloc_s);
      flush_done_r   <= empty_s & ~alloc_s;
    end else begin
      flush_done_r   <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_tag   = out_tag_r;
  assign bus.out_line  = out_line_r;
  assign bus.out_mask  = out_mask_r;
  assign flush_done    = flush_done_r;
  assign empty         = empty_s;
  assign full          = full_s;
endmodule

// File: tb/tb_line_write_merge_buffer.sv
// Bench for line_write_merge_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the buffer's rules.
module tb_line_write_merge_buffer;
  localparam int LB    = 16;
  localparam int WB    = 2;
  localparam int AW    = 16;
  localparam int DEPTH = 2;
  localparam int TAG_W = AW - 4;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [8*LB-1:0]  line;
    logic [LB-1:0]    mask;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic flush_done;
  logic empty;
  logic full;

  always #5 clk = ~clk;

  line_write_merge_buffer_if #(.ADDR_W(AW), .WORD_BYTES(WB), .LINE_BYTES(LB)) bus ();

  line_write_merge_buffer #(.LINE_BYTES(LB), .WORD_BYTES(WB), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .flush      (flush),
    .flush_done (flush_done),
    .empty      (empty),
    .full       (full)
  );

  int n_cmp = 0;
  int n_mis = 0;

  ent_t q[$];
  bit   m_pres;
  ent_t m_out;
  bit   m_fa;
  bit   m_fd;
  logic [TAG_W-1:0] dut_tags[$];
  logic [LB-1:0]    dut_masks[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int find_hit(input logic [TAG_W-1:0] t);
    for (int i = 0; i < q.size(); i++) begin
      if (!(m_pres && i == 0) && q[i].tag == t) return i;
    end
    return -1;
  endfunction

  function automatic ent_t put_word(input ent_t e, input logic [AW-1:0] addr,
                                    input logic [15:0] data, input logic [1:0] be);
    int pos;
    for (int i = 0; i < WB; i++) begin
      pos = ((addr % LB) / WB) * WB + i;
      if (be[i]) begin
        e.line[8*pos +: 8] = data[8*i +: 8];
        e.mask[pos] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic step(input bit rst, input bit v, input logic [AW-1:0] addr,
                      input logic [15:0] data, input logic [1:0] be,
                      input bit fl, input bit rdy, output bit acc);
    bit exp_rdy, start, alloc, nfd;
    int h, sz;
    ent_t e;
    @(negedge clk);
    reset = rst; bus.wr_valid = v; bus.wr_addr = addr; bus.wr_data = data;
    bus.wr_be = be; flush = fl; bus.out_ready = rdy;
    #1;
    h = find_hit(addr[AW-1:4]);
    exp_rdy = !m_fa && (h >= 0 || q.size() < DEPTH);
    check_eq("wr_ready", bus.wr_ready, exp_rdy);
    check_eq("out_valid", bus.out_valid, m_pres);
    check_eq("empty", empty, q.size() == 0);
    check_eq("full", full, q.size() == DEPTH);
    check_eq("flush_done", flush_done, m_fd);
    if (m_pres) begin
      check_eq("out_tag", bus.out_tag, m_out.tag);
      check_eq("out_line", bus.out_line, m_out.line);
      check_eq("out_mask", bus.out_mask, m_out.mask);
    end
    if (bus.out_valid === 1'b1 && rdy) begin
      dut_tags.push_back(bus.out_tag);
      dut_masks.push_back(bus.out_mask);
    end
    acc = v && exp_rdy;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_pres = 1'b0; m_fa = 1'b0; m_fd = 1'b0;
      return;
    end
    sz = q.size();
    start = !m_pres && sz > 0 && (sz == DEPTH || m_fa);
    alloc = 1'b0;
    if (acc && be != 2'b00) begin
      if (h >= 0) begin
        q[h] = put_word(q[h], addr, data, be);
      end else begin
        e.tag = addr[AW-1:4]; e.line = '0; e.mask = '0;
        q.push_back(put_word(e, addr, data, be));
        alloc = 1'b1;
      end
    end
    nfd = 1'b0;
    if (m_fa) begin
      if (sz == 0) begin m_fa = 1'b0; nfd = 1'b1; end
    end else if (fl) begin
      if (sz == 0 && !alloc) nfd = 1'b1;
      else m_fa = 1'b1;
    end
    if (m_pres) begin
      if (rdy) begin void'(q.pop_front()); m_pres = 1'b0; end
    end else if (start) begin
      m_pres = 1'b1; m_out = q[0];
    end
    m_fd = nfd;
  endtask

  task automatic idle(input int n, input bit rdy);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 2'b00, 0, rdy, a);
  endtask

  task automatic wait_pres(input int maxc);
    bit a;
    for (int i = 0; i < maxc && !m_pres; i++) step(0, 0, '0, '0, 2'b00, 0, 0, a);
    #1;
    check_eq("present_wait", bus.out_valid, 1'b1);
  endtask

  task automatic drain_all();
    bit a;
    step(0, 0, '0, '0, 2'b00, 1, 1, a);
    for (int i = 0; i < 40 && (m_fa || m_pres || q.size() != 0); i++)
      step(0, 0, '0, '0, 2'b00, 0, 1, a);
    idle(2, 1);
    check_eq("drain_empty", empty, 1'b1);
  endtask

  task automatic do_reset();
    bit a;
    step(1, 0, '0, '0, 2'b00, 0, 0, a);
  endtask

  initial begin
    bit a;
    int tries;
    reset = 1'b1; flush = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    m_pres = 1'b0; m_fa = 1'b0; m_fd = 1'b0;

    // Two merged writes, flush, single line out.
    step(0, 1, 16'h0102, 16'hABCD, 2'b11, 0, 0, a);
    step(0, 1, 16'h0106, 16'h0012, 2'b01, 0, 0, a);
    step(0, 0, '0, '0, 2'b00, 1, 0, a);
    wait_pres(10);
    check_eq("t1_tag", bus.out_tag, 12'h010);
    check_eq("t1_mask", bus.out_mask, 16'h004C);
    check_eq("t1_line", bus.out_line, 128'h0000_0000_0000_0000_0012_0000_ABCD_0000);
    idle(6, 1);

    // Full stall: third tag waits for the first pop.
    do_reset();
    dut_tags.delete(); dut_masks.delete();
    step(0, 1, 16'h0000, 16'h1111, 2'b11, 0, 1, a);
    step(0, 1, 16'h0010, 16'h2222, 2'b11, 0, 1, a);
    tries = 0; a = 1'b0;
    while (!a && tries < 20) begin
      step(0, 1, 16'h0020, 16'h3333, 2'b11, 0, 1, a);
      tries++;
    end
    check_eq("t2_stalled", tries > 1, 1'b1);
    drain_all();
    check_eq("t2_count", dut_tags.size(), 3);
    check_eq("t2_first", dut_tags[0], 12'h000);
    check_eq("t2_second", dut_tags[1], 12'h001);

    // Locked head: same tag re-allocates and is emitted twice.
    do_reset();
    dut_tags.delete(); dut_masks.delete();
    step(0, 1, 16'h0030, 16'h0011, 2'b01, 0, 0, a);
    step(0, 1, 16'h0040, 16'h4444, 2'b11, 0, 0, a);
    wait_pres(10);
    for (int i = 0; i < 5; i++) step(0, 1, 16'h0032, 16'h2200, 2'b10, 0, 0, a);
    tries = 0; a = 1'b0;
    while (!a && tries < 20) begin
      step(0, 1, 16'h0032, 16'h2200, 2'b10, 0, 1, a);
      tries++;
    end
    drain_all();
    check_eq("t3_count", dut_tags.size(), 3);
    check_eq("t3_tag0", dut_tags[0], 12'h003);
    check_eq("t3_tag2", dut_tags[2], 12'h003);
    check_eq("t3_mask2", dut_masks[2], 16'h0008);

    // Top byte of the line, then reset while presented and stalled.
    step(0, 1, 16'h000E, 16'h5A00, 2'b10, 0, 0, a);
    step(0, 0, '0, '0, 2'b00, 1, 0, a);
    wait_pres(10);
    check_eq("t4_mask", bus.out_mask, 16'h8000);
    check_eq("t4_byte15", bus.out_line[127:120], 8'h5A);
    do_reset();
    #1;
    check_eq("t5_out_valid", bus.out_valid, 1'b0);
    check_eq("t5_empty", empty, 1'b1);
    check_eq("t5_full", full, 1'b0);
    check_eq("t5_wr_ready", bus.wr_ready, 1'b1);

    // Flush while empty: one-cycle done, nothing presented.
    step(0, 0, '0, '0, 2'b00, 1, 1, a);
    #1;
    check_eq("t6_done", flush_done, 1'b1);
    check_eq("t6_valid", bus.out_valid, 1'b0);
    idle(1, 1);
    #1;
    check_eq("t6_done_low", flush_done, 1'b0);
    check_eq("t6_valid_low", bus.out_valid, 1'b0);

    // Random traffic over a few tags.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0,
           AW'($urandom_range(0, 63)), 16'($urandom), 2'($urandom_range(0, 3)),
           $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, a);
    end
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
